// File: rtl/mw_add_seq.sv
// mw_add_seq: multi-word add/subtract sequencer built around one 16-bit
// carry look-ahead adder section. It computes WORDS x 16-bit sums or
// differences by processing one 16-bit word per clock, low word first. The
// carry (or inverted borrow) is chained between words in a register.
//
// Ports:
//   cp2     in   clock, rising edge
//   ireset  in   asynchronous active-low reset
//   start   in   operation request, sampled while not busy
//   sub     in   0: A+B+ci_in, 1: A-B-ci_in (sampled with start)
//   ci_in   in   carry-in for add, borrow-in for sub (sampled with start)
//   a_in    in   operand A, N = 16*WORDS bits (sampled with start)
//   b_in    in   operand B, N bits (sampled with start)
//   busy    out  high while words are being processed
//   done    out  one-cycle pulse when results become valid
//   s_out   out  N-bit result, held until the next operation completes
//   co_out  out  carry out (add) or borrow out (sub)
//   z_out   out  result is zero
//   v_out   out  signed two's-complement overflow
//
// Configuration macro: MW_ADD_SEQ_FLAGS_EN
//   defined   - z_out / v_out are computed; zero is accumulated per word
//   undefined - z_out / v_out are tied to 0 and their registers are absent

// 16-bit carry look-ahead adder: four 4-bit groups with group-level lookahead.
module cla16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  pg;
  logic [4:0]  cg;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate, group carries, then per-bit carries in each group.
  always_comb begin
    gg = '0;
    pg = '0;
    cg = '0;
    c  = '0;
    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      pg[j] = &p[4*j +: 4];
    end
    cg[0] = ci;
    cg[1] = gg[0] | (pg[0] & ci);
    cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & ci);
    cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
          | (pg[2] & pg[1] & pg[0] & ci);
    cg[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
          | (pg[3] & pg[2] & pg[1] & gg[0]) | ((&pg) & ci);
    for (int j = 0; j < 4; j++) begin
      c[4*j]   = cg[j];
      c[4*j+1] = g[4*j] | (p[4*j] & cg[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & cg[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & cg[j]);
    end
  end

  assign s  = p ^ c;
  assign co = cg[4];

endmodule

module mw_add_seq #(
  parameter int unsigned WORDS = 4
) (
  input  logic                  cp2,
  input  logic                  ireset,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  ci_in,
  input  logic [16*WORDS-1:0]   a_in,
  input  logic [16*WORDS-1:0]   b_in,
  output logic                  busy,
  output logic                  done,
  output logic [16*WORDS-1:0]   s_out,
  output logic                  co_out,
  output logic                  z_out,
  output logic                  v_out
);

  localparam int unsigned W  = 16;
  localparam int unsigned N  = W * WORDS;
  localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q;
  state_e          state_d;
  logic            busy_d;
  logic            done_d;

  logic [KW-1:0]   k_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [N-1:0]    acc_q;
  logic            sub_q;
  logic            cy_q;

  logic            accept_c;
  logic            last_word_c;
  logic [W-1:0]    b_word_c;
  logic [W-1:0]    sum_c;
  logic            cout_c;

  // A request is taken in IDLE and also in DONE, for back-to-back operation.
  assign accept_c    = start && (state_q != ST_RUN);
  assign last_word_c = (state_q == ST_RUN) && (k_q == KW'(WORDS - 1));

  // Subtraction is A + ~B + ~borrow; the inversion is applied per word.
  assign b_word_c = b_q[W-1:0] ^ {W{sub_q}};

  cla16b u_cla (
    .a  (a_q[W-1:0]),
    .b  (b_word_c),
    .ci (cy_q),
    .s  (sum_c),
    .co (cout_c)
  );

  // State register.
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_word_c) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the next state so they register in step with it.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    if (state_d == ST_RUN)  busy_d = 1'b1;
    if (state_d == ST_DONE) done_d = 1'b1;
  end

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
    end
  end

  // Operand shift registers, carry chain, partial-sum register and results.
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      sub_q  <= 1'b0;
      cy_q   <= 1'b0;
      k_q    <= '0;
      s_out  <= '0;
      co_out <= 1'b0;
    end else if (accept_c) begin
      a_q   <= a_in;
      b_q   <= b_in;
      sub_q <= sub;
      cy_q  <= sub ? ~ci_in : ci_in;
      k_q   <= '0;
    end else if (state_q == ST_RUN) begin
      acc_q <= {sum_c, acc_q[N-1:W]};
      cy_q  <= cout_c;
      a_q   <= a_q >> W;
      b_q   <= b_q >> W;
      k_q   <= last_word_c ? '0 : k_q + KW'(1);
      if (last_word_c) begin
        s_out  <= {sum_c, acc_q[N-1:W]};
        co_out <= cout_c ^ sub_q;
      end
    end
  end

`ifdef MW_ADD_SEQ_FLAGS_EN
  logic zacc_q;

  // Zero flag is accumulated one word at a time; overflow uses the top word's MSBs.
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      zacc_q <= 1'b0;
      z_out  <= 1'b0;
      v_out  <= 1'b0;
    end else if (accept_c) begin
      zacc_q <= 1'b1;
    end else if (state_q == ST_RUN) begin
      zacc_q <= zacc_q & ~(|sum_c);
      if (last_word_c) begin
        z_out <= zacc_q & ~(|sum_c);
        v_out <= (a_q[W-1] == b_word_c[W-1]) && (sum_c[W-1] != a_q[W-1]);
      end
    end
  end
`else
  assign z_out = 1'b0;
  assign v_out = 1'b0;
`endif

endmodule

// File: tb/tb_mw_add_seq.sv
// Self-checking bench for mw_add_seq (WORDS=4): directed vector table,
// hand-written multi-cycle sequences and randomized operations against an
// arithmetic reference model.
module tb_mw_add_seq;

  localparam int unsigned WORDS = 4;
  localparam int unsigned N     = 64;
`ifdef MW_ADD_SEQ_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic         cp2;
  logic         ireset;
  logic         start;
  logic         sub;
  logic         ci_in;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic         busy;
  logic         done;
  logic [N-1:0] s_out;
  logic         co_out;
  logic         z_out;
  logic         v_out;

  int checks = 0;
  int errors = 0;

  mw_add_seq #(.WORDS(WORDS)) dut (
    .cp2    (cp2),
    .ireset (ireset),
    .start  (start),
    .sub    (sub),
    .ci_in  (ci_in),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .s_out  (s_out),
    .co_out (co_out),
    .z_out  (z_out),
    .v_out  (v_out)
  );

  initial cp2 = 1'b0;
  always #5 cp2 = ~cp2;

  typedef struct {
    string        name;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         ci;
    logic [N-1:0] s;
    logic         co;
    logic         z;
    logic         v;
  } vec_t;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic; overflow from an exact signed result.
  task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                       input logic c, output logic [N-1:0] r, output logic co,
                       output logic z, output logic v);
    logic [N:0]          u;
    logic signed [N+1:0] sa;
    logic signed [N+1:0] sb;
    logic signed [N+1:0] sr;
    sa = {{2{a[N-1]}}, a};
    sb = {{2{b[N-1]}}, b};
    if (!s) begin
      u  = {1'b0, a} + {1'b0, b} + (N+1)'(c);
      sr = sa + sb + $signed((N+2)'(c));
    end else begin
      u  = {1'b0, a} - {1'b0, b} - (N+1)'(c);
      sr = sa - sb - $signed((N+2)'(c));
    end
    r  = u[N-1:0];
    co = u[N];
    z  = FLAGS && (r == '0);
    v  = FLAGS && (sr[N] != sr[N-1]);
  endtask

  // Single operation: start for one cycle, measure latency, check results and pulse width.
  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic s, input logic c, input logic [N-1:0] es,
                        input logic eco, input logic ez, input logic ev);
    int nb;
    int cyc;
    bit seen;
    @(negedge cp2);
    a_in = a; b_in = b; sub = s; ci_in = c; start = 1'b1;
    @(posedge cp2);
    #1 start = 1'b0;
    nb = 0; cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge cp2);
      cyc++;
      if (done) seen = 1'b1;
      else if (busy) nb++;
    end
    check({tag, "_done_seen"}, N'(seen), N'(1));
    check({tag, "_latency"}, N'(cyc), N'(WORDS + 1));
    check({tag, "_busy_cycles"}, N'(nb), N'(WORDS));
    check({tag, "_s"}, s_out, es);
    check({tag, "_co"}, N'(co_out), N'(eco));
    check({tag, "_z"}, N'(z_out), N'(ez));
    check({tag, "_v"}, N'(v_out), N'(ev));
    @(negedge cp2);
    check({tag, "_done_width"}, N'(done), N'(0));
    check({tag, "_s_held"}, s_out, es);
  endtask

  vec_t tbl[8];

  initial begin
    logic [N-1:0] es;
    logic         eco, ez, ev;
    logic [N-1:0] ra, rb;
    logic         rs, rc;
    int           ndone;
    logic [N-1:0] first_s;
    bit           ok;

    ireset = 1'b0; start = 1'b0; sub = 1'b0; ci_in = 1'b0; a_in = '0; b_in = '0;

    tbl[0] = '{"all_ones_plus_ci", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1,
               64'h0, 1'b1, FLAGS, 1'b0};
    tbl[1] = '{"zero_minus_one", 64'h0, 64'h1, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{"pos_overflow", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b0, FLAGS};
    tbl[3] = '{"carry_chain", 64'h0001_0000_FFFF_0001, 64'h0000_FFFF_0001_FFFF, 1'b0, 1'b0,
               64'h0002_0000_0001_0000, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{"sub_borrow_in", 64'h5, 64'h3, 1'b1, 1'b1,
               64'h1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{"neg_overflow", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, FLAGS};
    tbl[6] = '{"zero_minus_borrow", 64'h0, 64'h0, 1'b1, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{"equal_sub_zero", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0,
               64'h0, 1'b0, FLAGS, 1'b0};

    // Reset state
    repeat (3) @(posedge cp2);
    #1;
    check("reset_busy", N'(busy), N'(0));
    check("reset_done", N'(done), N'(0));
    check("reset_s", s_out, '0);
    check("reset_flags", N'({co_out, z_out, v_out}), N'(0));
    @(negedge cp2);
    ireset = 1'b1;

    // Directed vector table
    for (int i = 0; i < 8; i++)
      run_op(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].ci,
             tbl[i].s, tbl[i].co, tbl[i].z, tbl[i].v);

    // Start during RUN is ignored: one done, first operation's result
    model(64'h1111_2222_3333_4444, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b1, es, eco, ez, ev);
    @(negedge cp2);
    a_in = 64'h1111_2222_3333_4444; b_in = 64'h0F0F_0F0F_0F0F_0F0F; sub = 1'b0; ci_in = 1'b1;
    start = 1'b1;
    @(posedge cp2);
    #1 start = 1'b0;
    @(negedge cp2);
    a_in = 64'hDEAD_BEEF_0000_0001; b_in = 64'h0000_0000_0000_0001; sub = 1'b1; start = 1'b1;
    @(posedge cp2);
    @(posedge cp2);
    #1 start = 1'b0;
    ndone = 0; first_s = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge cp2);
      if (done) begin
        if (ndone == 0) first_s = s_out;
        ndone++;
      end
    end
    check("ignore_start_ndone", N'(ndone), N'(1));
    check("ignore_start_s", first_s, es);

    // Reset during the second RUN cycle aborts the operation
    @(negedge cp2);
    a_in = 64'h0123_4567_89AB_CDEF; b_in = 64'h1; sub = 1'b0; ci_in = 1'b0; start = 1'b1;
    @(posedge cp2);
    #1 start = 1'b0;
    @(posedge cp2);
    #2 ireset = 1'b0;
    #1;
    check("abort_busy", N'(busy), N'(0));
    check("abort_s", s_out, '0);
    check("abort_flags", N'({done, co_out, z_out, v_out}), N'(0));
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge cp2);
      if (c == 3) ireset = 1'b1;
      if (done) ndone++;
    end
    check("abort_no_done", N'(ndone), N'(0));
    run_op("after_abort", 64'h0001_0000_FFFF_0001, 64'h0000_FFFF_0001_FFFF, 1'b0, 1'b0,
           64'h0002_0000_0001_0000, 1'b0, 1'b0, 1'b0);

    // Randomized single operations with occasional corner operands
    for (int i = 0; i < 30; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ra = '1;
        1: rb = '0;
        2: rb = ra;
        3: ra = {1'b0, {(N-1){1'b1}}};
        default: ;
      endcase
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      model(ra, rb, rs, rc, es, eco, ez, ev);
      run_op($sformatf("rand%0d", i), ra, rb, rs, rc, es, eco, ez, ev);
    end

    // Back-to-back: start held high, one operation every WORDS+1 cycles
    @(negedge cp2);
    ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
    rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
    a_in = ra; b_in = rb; sub = rs; ci_in = rc; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      model(ra, rb, rs, rc, es, eco, ez, ev);
      @(posedge cp2);
      ok = 1'b1;
      for (int c = 1; c <= WORDS + 1; c++) begin
        @(negedge cp2);
        if (c <= WORDS) ok = ok && busy && !done;
        else            ok = ok && done && !busy;
      end
      check($sformatf("b2b%0d_timing", i), N'(ok), N'(1));
      check($sformatf("b2b%0d_s", i), s_out, es);
      check($sformatf("b2b%0d_co", i), N'(co_out), N'(eco));
      check($sformatf("b2b%0d_zv", i), N'({z_out, v_out}), N'({ez, ev}));
      if (i < 7) begin
        ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
        rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
        a_in = ra; b_in = rb; sub = rs; ci_in = rc;
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge cp2);
    check("final_idle_busy", N'(busy), N'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
